// File: rtl/uart_pkg.sv
// Shared types and encodings for the uart_tx arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_STARTUP  = 3'd0,
        ST_IDLE     = 3'd1,
        ST_FLAG     = 3'd2,
        ST_WAIT_END = 3'd3,
        ST_GAP      = 3'd4
    } state_t;

    localparam logic [1:0] PARI_NONE = 2'b00;
    localparam logic [1:0] PARI_ODD  = 2'b01;
    localparam logic [1:0] PARI_EVEN = 2'b10;

    localparam logic STOP_1 = 1'b0;
    localparam logic STOP_2 = 1'b1;

    // The unused 2'b11 parity code is sent to uart_tx as "no parity".
    function automatic logic [1:0] legal_parity(input logic [1:0] p);
        return ((p == PARI_ODD) || (p == PARI_EVEN)) ? p : PARI_NONE;
    endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Round-robin winner select: first valid requester above the pointer, with wrap.
// Latency: purely combinational.
// Backpressure: none; any_valid_o is low when no requester is valid.
module uart_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IW      = 2
) (
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic [IW-1:0]      ptr_i,
    output logic [IW-1:0]      winner_o,
    output logic               any_valid_o
);

    // Scan ptr+1 .. ptr+NUM_REQ (mod NUM_REQ); the pointer itself has lowest priority.
    always_comb begin
        logic        found;
        logic [IW-1:0] win;
        int          idx;
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            idx = (int'(ptr_i) + off) % NUM_REQ;
            if (!found && valid_i[idx[IW-1:0]]) begin
                found = 1'b1;
                win   = idx[IW-1:0];
            end
        end
        winner_o    = win;
        any_valid_o = found;
    end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin sharing of one uart_tx between NUM_REQ byte producers; optional txend watchdog (UART_TX_ARB_TIMEOUT_EN).
// Latency: ready is combinational in IDLE; pi_flag_o rises the cycle after the handshake for FLAG_CYCLES cycles.
// Backpressure: one grant per frame; requesters hold valid/data until their ready, new grants wait for txend_i plus GAP_CYCLES.
module uart_tx_arb
    import uart_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int STARTUP_CYCLES = 8,
    parameter int FLAG_CYCLES    = 2,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic                       clk_i,
    input  logic                       rstn_i,
    input  logic [NUM_REQ-1:0]         req_valid_i,
    input  logic [NUM_REQ*8-1:0]       req_data_i,
    output logic [NUM_REQ-1:0]         req_ready_o,
    input  logic [31:0]                cfg_baud_cnt_max_i,
    input  logic [31:0]                cfg_baud_cnt_max_half_i,
    input  logic [1:0]                 cfg_paribit_i,
    input  logic                       cfg_stopbit_i,
    output logic [7:0]                 pi_data_o,
    output logic                       pi_flag_o,
    output logic [31:0]                baud_cnt_max_o,
    output logic [31:0]                baud_cnt_max_half_o,
    output logic [1:0]                 paribit_o,
    output logic                       stopbit_o,
    input  logic                       txend_i,
    output logic                       busy_o,
    output logic [$clog2(NUM_REQ)-1:0] grant_id_o,
    output logic                       frame_done_o,
    output logic                       timeout_o
);

    localparam int IW = $clog2(NUM_REQ);

    state_t         state_q;
    logic [31:0]    cnt_q;      // startup / flag / gap length, and watchdog in WAIT_END
    logic [IW-1:0]  ptr_q;
    logic [IW-1:0]  grant_q;
    logic [7:0]     data_q;
    logic           flag_q;
    logic           busy_q;
    logic           done_q;
    logic [31:0]    baud_q;
    logic [31:0]    half_q;
    logic [1:0]     pari_q;
    logic           stop_q;

    logic [IW-1:0]  win;
    logic           any_valid;
    logic           handshake;

    uart_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_pick (
        .valid_i     (req_valid_i),
        .ptr_i       (ptr_q),
        .winner_o    (win),
        .any_valid_o (any_valid)
    );

    assign handshake = (state_q == ST_IDLE) && any_valid;

    // One-hot ready to the round-robin winner, only while IDLE.
    always_comb begin
        req_ready_o = '0;
        if (handshake) begin
            req_ready_o[win] = 1'b1;
        end
    end

`ifdef UART_TX_ARB_TIMEOUT_EN
    logic timeout_q;
    assign timeout_o = timeout_q;
`else
    // Watchdog limit only matters in the timeout build.
    logic unused_timeout_cycles;
    assign unused_timeout_cycles = |TIMEOUT_CYCLES;
    assign timeout_o = 1'b0;
`endif

    // Frame sequencer: grant, flag strobe, wait for txend, inter-frame gap.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q   <= ST_STARTUP;
            cnt_q     <= '0;
            ptr_q     <= IW'(NUM_REQ - 1);
            grant_q   <= '0;
            data_q    <= '0;
            flag_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            baud_q    <= '0;
            half_q    <= '0;
            pari_q    <= PARI_NONE;
            stop_q    <= STOP_1;
`ifdef UART_TX_ARB_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
            case (state_q)
                ST_STARTUP: begin
                    baud_q <= cfg_baud_cnt_max_i;
                    half_q <= cfg_baud_cnt_max_half_i;
                    pari_q <= legal_parity(cfg_paribit_i);
                    stop_q <= cfg_stopbit_i;
                    if (cnt_q == 32'(STARTUP_CYCLES - 1)) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                    end else begin
                        busy_q  <= 1'b1;
                        cnt_q   <= cnt_q + 32'd1;
                    end
                end
                ST_IDLE: begin
                    // Config tracks the inputs here; the handshake-edge copy is the frame's value.
                    baud_q <= cfg_baud_cnt_max_i;
                    half_q <= cfg_baud_cnt_max_half_i;
                    pari_q <= legal_parity(cfg_paribit_i);
                    stop_q <= cfg_stopbit_i;
                    if (handshake) begin
                        data_q  <= req_data_i[{win, 3'b000} +: 8];
                        grant_q <= win;
                        ptr_q   <= win;
                        flag_q  <= 1'b1;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= ST_FLAG;
                    end
                end
                ST_FLAG: begin
                    if (cnt_q == 32'(FLAG_CYCLES - 1)) begin
                        flag_q  <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= ST_WAIT_END;
                    end else begin
                        cnt_q   <= cnt_q + 32'd1;
                    end
                end
                ST_WAIT_END: begin
                    if (txend_i) begin
                        done_q  <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= ST_GAP;
`ifdef UART_TX_ARB_TIMEOUT_EN
                    end else if (cnt_q == 32'(TIMEOUT_CYCLES - 1)) begin
                        // Give up on this frame; pointer already moved past the requester.
                        timeout_q <= 1'b1;
                        cnt_q     <= '0;
                        state_q   <= ST_GAP;
                    end else begin
                        cnt_q     <= cnt_q + 32'd1;
`endif
                    end
                end
                ST_GAP: begin
                    if (cnt_q == 32'(GAP_CYCLES - 1)) begin
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q   <= cnt_q + 32'd1;
                    end
                end
                default: begin
                    flag_q  <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= ST_STARTUP;
                end
            endcase
        end
    end

    assign pi_data_o           = data_q;
    assign pi_flag_o           = flag_q;
    assign baud_cnt_max_o      = baud_q;
    assign baud_cnt_max_half_o = half_q;
    assign paribit_o           = pari_q;
    assign stopbit_o           = stop_q;
    assign busy_o              = busy_q;
    assign grant_id_o          = grant_q;
    assign frame_done_o        = done_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb: startup, round-robin order, config hold, txend filtering, reset mid-frame.
// Latency: expectations are hand-computed per cycle from the handshake edge.
// Backpressure: requesters hold valid until the bench observes their ready.
module tb_uart_tx_arb;

    logic        clk = 1'b0;
    logic        rstn;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic [31:0] cfg_baud, cfg_half;
    logic [1:0]  cfg_pari;
    logic        cfg_stop;
    logic [7:0]  pi_data;
    logic        pi_flag;
    logic [31:0] baud_o, half_o;
    logic [1:0]  pari_o;
    logic        stop_o;
    logic        txend;
    logic        busy;
    logic [1:0]  grant_id;
    logic        frame_done;
    logic        timeout;

    always #5 clk = ~clk;

    uart_tx_arb #(
        .NUM_REQ        (4),
        .STARTUP_CYCLES (8),
        .FLAG_CYCLES    (2),
        .GAP_CYCLES     (2),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk_i                   (clk),
        .rstn_i                  (rstn),
        .req_valid_i             (req_valid),
        .req_data_i              (req_data),
        .req_ready_o             (req_ready),
        .cfg_baud_cnt_max_i      (cfg_baud),
        .cfg_baud_cnt_max_half_i (cfg_half),
        .cfg_paribit_i           (cfg_pari),
        .cfg_stopbit_i           (cfg_stop),
        .pi_data_o               (pi_data),
        .pi_flag_o               (pi_flag),
        .baud_cnt_max_o          (baud_o),
        .baud_cnt_max_half_o     (half_o),
        .paribit_o               (pari_o),
        .stopbit_o               (stop_o),
        .txend_i                 (txend),
        .busy_o                  (busy),
        .grant_id_o              (grant_id),
        .frame_done_o            (frame_done),
        .timeout_o               (timeout)
    );

    int passed = 0;
    int total  = 0;

    // Flag-pulse monitor: low cycles between pulses and pulse count.
    logic mon_en    = 1'b0;
    logic prev_flag = 1'b0;
    logic seen      = 1'b0;
    int   lowcnt    = 0;
    int   min_gap   = 1000;
    int   pulses    = 0;
    logic to_seen   = 1'b0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (pi_flag) begin
                if (!prev_flag) begin
                    if (seen && lowcnt < min_gap) min_gap = lowcnt;
                    pulses = pulses + 1;
                end
                seen   = 1'b1;
                lowcnt = 0;
            end else begin
                lowcnt = lowcnt + 1;
            end
            prev_flag = pi_flag;
        end
        if (timeout) to_seen = 1'b1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Advance at least one cycle, then until IDLE (busy low), bounded.
    task automatic wait_idle(input string name);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (busy && n < 40);
        chk(name, {31'd0, busy}, 32'd0);
    endtask

    // Called just after the handshake edge: flag width, txend after dly cycles, done pulse.
    task automatic run_frame(input int dly, input string tag);
        chk({tag, "_flag1"}, {31'd0, pi_flag}, 32'd1);
        tick();
        chk({tag, "_flag2"}, {31'd0, pi_flag}, 32'd1);
        tick();
        chk({tag, "_flag_off"}, {31'd0, pi_flag}, 32'd0);
        repeat (dly) tick();
        txend = 1'b1;
        tick();
        txend = 1'b0;
        chk({tag, "_done"}, {31'd0, frame_done}, 32'd1);
        tick();
        chk({tag, "_done_off"}, {31'd0, frame_done}, 32'd0);
    endtask

    typedef struct {
        logic [3:0] valid;
        logic [3:0] ready;
        logic [7:0] data;
        logic [1:0] grant;
    } vec_t;

    vec_t vecs[9];

    initial begin
        vecs[0] = '{4'b1111, 4'b0001, 8'h11, 2'd0};
        vecs[1] = '{4'b1111, 4'b0010, 8'h22, 2'd1};
        vecs[2] = '{4'b1111, 4'b0100, 8'h33, 2'd2};
        vecs[3] = '{4'b1111, 4'b1000, 8'h44, 2'd3};
        vecs[4] = '{4'b1111, 4'b0001, 8'h11, 2'd0};
        vecs[5] = '{4'b1010, 4'b0010, 8'h22, 2'd1};
        vecs[6] = '{4'b1001, 4'b1000, 8'h44, 2'd3};
        vecs[7] = '{4'b0110, 4'b0010, 8'h22, 2'd1};
        vecs[8] = '{4'b0010, 4'b0010, 8'h22, 2'd1};

        rstn      = 1'b0;
        req_valid = 4'b0000;
        req_data  = 32'h4433_2211;
        cfg_baud  = 32'h0000_1234;
        cfg_half  = 32'h0000_091A;
        cfg_pari  = 2'b01;
        cfg_stop  = 1'b0;
        txend     = 1'b0;

        // ---- reset state and startup delay ----
        repeat (3) tick();
        chk("rst_flag",  {31'd0, pi_flag}, 32'd0);
        chk("rst_busy",  {31'd0, busy}, 32'd0);
        chk("rst_ready", {28'd0, req_ready}, 32'd0);
        chk("rst_data",  {24'd0, pi_data}, 32'd0);
        chk("rst_baud",  baud_o, 32'd0);
        chk("rst_done",  {31'd0, frame_done}, 32'd0);
        chk("rst_to",    {31'd0, timeout}, 32'd0);
        req_valid = 4'b0001;
        rstn      = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("startup_ready_%0d", i), {28'd0, req_ready}, (i == 7) ? 32'd1 : 32'd0);
            if (i == 0) begin
                chk("baud_first_edge", baud_o, 32'h1234);
                chk("half_first_edge", half_o, 32'h091A);
            end
        end
        tick();
        chk("t1_flag", {31'd0, pi_flag}, 32'd1);
        chk("t1_data", {24'd0, pi_data}, 32'h11);
        chk("t1_grant", {30'd0, grant_id}, 32'd0);
        chk("t1_busy", {31'd0, busy}, 32'd1);
        chk("t1_ready_flag", {28'd0, req_ready}, 32'd0);
        req_valid = 4'b0000;
        txend = 1'b1;                       // txend during FLAG must be ignored
        tick();
        txend = 1'b0;
        chk("t1_flag2", {31'd0, pi_flag}, 32'd1);
        tick();
        chk("t1_flag_off", {31'd0, pi_flag}, 32'd0);
        chk("t1_no_done_flag_txend", {31'd0, frame_done}, 32'd0);
        repeat (5) tick();
        chk("t1_still_waiting", {31'd0, busy}, 32'd1);
        chk("t1_no_done_wait", {31'd0, frame_done}, 32'd0);
        txend = 1'b1;
        tick();
        txend = 1'b0;
        chk("t1_done", {31'd0, frame_done}, 32'd1);
        tick();
        chk("t1_done_one_cycle", {31'd0, frame_done}, 32'd0);
        tick();
        chk("t1_idle", {31'd0, busy}, 32'd0);
        txend = 1'b1;                       // txend during IDLE must be ignored
        tick();
        txend = 1'b0;
        chk("t1_no_done_idle", {31'd0, frame_done}, 32'd0);
        chk("t1_idle_busy", {31'd0, busy}, 32'd0);

        // ---- config held across the frame ----
        req_valid = 4'b0010;
        #1;
        chk("t2_ready", {28'd0, req_ready}, 32'h2);
        tick();
        chk("t2_data", {24'd0, pi_data}, 32'h22);
        chk("t2_grant", {30'd0, grant_id}, 32'd1);
        chk("t2_pari_a", {30'd0, pari_o}, 32'h1);
        req_valid = 4'b0000;
        repeat (2) tick();
        cfg_pari = 2'b10;
        cfg_stop = 1'b1;
        cfg_baud = 32'h0000_5678;
        cfg_half = 32'h0000_2B3C;
        repeat (3) tick();
        chk("t2_pari_hold", {30'd0, pari_o}, 32'h1);
        chk("t2_stop_hold", {31'd0, stop_o}, 32'd0);
        chk("t2_baud_hold", baud_o, 32'h1234);
        txend = 1'b1;
        tick();
        txend = 1'b0;
        chk("t2_done", {31'd0, frame_done}, 32'd1);
        chk("t2_pari_gap", {30'd0, pari_o}, 32'h1);
        tick();
        chk("t2_stop_gap", {31'd0, stop_o}, 32'd0);
        req_valid = 4'b0010;
        wait_idle("t2_wait_idle");
        chk("t2b_ready", {28'd0, req_ready}, 32'h2);
        tick();
        req_valid = 4'b0000;
        chk("t2b_pari", {30'd0, pari_o}, 32'h2);
        chk("t2b_stop", {31'd0, stop_o}, 32'd1);
        chk("t2b_baud", baud_o, 32'h5678);
        chk("t2b_half", half_o, 32'h2B3C);
        chk("t2b_data", {24'd0, pi_data}, 32'h22);
        run_frame(10, "t2b");

        // ---- reset asserted mid-FLAG ----
        req_valid = 4'b0100;
        wait_idle("t3_wait_idle");
        chk("t3_ready", {28'd0, req_ready}, 32'h4);
        tick();
        chk("t3_flag", {31'd0, pi_flag}, 32'd1);
        chk("t3_grant", {30'd0, grant_id}, 32'd2);
        req_valid = 4'b1111;
        rstn = 1'b0;
        #1;
        chk("t3_rst_flag", {31'd0, pi_flag}, 32'd0);
        chk("t3_rst_busy", {31'd0, busy}, 32'd0);
        chk("t3_rst_ready", {28'd0, req_ready}, 32'd0);
        chk("t3_rst_data", {24'd0, pi_data}, 32'd0);
        repeat (2) tick();
        rstn   = 1'b1;
        mon_en = 1'b1;

        // ---- round-robin table ----
        for (int i = 0; i < 9; i++) begin
            req_valid = vecs[i].valid;
            wait_idle($sformatf("v%0d_wait_idle", i));
            chk($sformatf("v%0d_ready", i), {28'd0, req_ready}, {28'd0, vecs[i].ready});
            tick();
            req_valid = 4'b0000;
            chk($sformatf("v%0d_data", i), {24'd0, pi_data}, {24'd0, vecs[i].data});
            chk($sformatf("v%0d_grant", i), {30'd0, grant_id}, {30'd0, vecs[i].grant});
            run_frame(50, $sformatf("v%0d", i));
        end
        mon_en = 1'b0;
        chk("rr_pulse_count", pulses, 32'd9);
        chk("rr_min_gap_ge2", {31'd0, (min_gap >= 2)}, 32'd1);

`ifdef UART_TX_ARB_TIMEOUT_EN
        // ---- txend watchdog ----
        begin
            int n;
            req_valid = 4'b1111;
            wait_idle("to_wait_idle");
            chk("to_ready", {28'd0, req_ready}, 32'h4);
            tick();
            chk("to_data", {24'd0, pi_data}, 32'h33);
            repeat (2) tick();
            chk("to_flag_off", {31'd0, pi_flag}, 32'd0);
            n = 0;
            do begin
                tick();
                n++;
            end while (!timeout && n < 300);
            chk("to_cycles", n, 32'd100);
            chk("to_no_done", {31'd0, frame_done}, 32'd0);
            tick();
            chk("to_one_cycle", {31'd0, timeout}, 32'd0);
            wait_idle("to_wait_idle2");
            chk("to_next_ready", {28'd0, req_ready}, 32'h8);
            tick();
            req_valid = 4'b0000;
            chk("to_next_data", {24'd0, pi_data}, 32'h44);
            chk("to_next_grant", {30'd0, grant_id}, 32'd3);
            run_frame(5, "to_next");
        end
`else
        chk("timeout_never", {31'd0, to_seen}, 32'd0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
